// File: rtl/eth10base_t_tx_framer.sv
// 10BASE-T transmit framer: preamble/SFD insertion, LSB-first Manchester encoding,
// TP_IDL frame close and Normal Link Pulses while idle.
module eth10base_t_tx_framer #(
   parameter int unsigned CLK_DIV        = 1,
   parameter int unsigned PREAMBLE_BYTES = 7,
   parameter int unsigned TPIDL_HALFBITS = 4,
   parameter int unsigned NLP_PERIOD     = 160000,
   parameter int unsigned NLP_HALFBITS   = 2
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] tx_data,
   input  logic       tx_valid,
   input  logic       tx_last,
   output logic       tx_ready,
   output logic       Txp,
   output logic       Txn,
   output logic       tx_busy,
   output logic       tx_underrun
);

   // state | meaning
   // IDLE  | lines 0/0, NLP counter running, waiting for tx_valid
   // NLP   | link pulse, Txp=1 Txn=0 for NLP_HALFBITS ticks
   // PRE   | PREAMBLE_BYTES x 0x55
   // SFD   | 0xD5, first tx_ready on its last half-bit
   // DATA  | payload bytes from the handshake
   // TPIDL | Txp=1 Txn=0 for TPIDL_HALFBITS ticks
   typedef enum logic [2:0] {S_IDLE, S_NLP, S_PRE, S_SFD, S_DATA, S_TPIDL} state_t;

   localparam logic [7:0]  DIV_LAST   = 8'(CLK_DIV - 1);
   localparam logic [3:0]  PRE_LAST   = 4'(PREAMBLE_BYTES - 1);
   localparam logic [7:0]  TPIDL_LAST = 8'(TPIDL_HALFBITS - 1);
   localparam logic [7:0]  NLP_LAST   = 8'(NLP_HALFBITS - 1);
   localparam logic [19:0] NLP_MAX    = 20'(NLP_PERIOD - 1);

   state_t      state_q, state_d;
   logic [7:0]  div_cnt_q, div_cnt_d;
   logic [7:0]  half_q, half_d;
   logic [3:0]  byte_cnt_q, byte_cnt_d;
   logic [7:0]  shift_q, shift_d;
   logic        last_q, last_d;
   logic [7:0]  hold_byte_q, hold_byte_d;
   logic        hold_last_q, hold_last_d;
   logic        hold_vld_q, hold_vld_d;
   logic [19:0] nlp_cnt_q, nlp_cnt_d;
   logic        nlp_ph_q, nlp_ph_d;
   logic        txp_q, txp_d;
   logic        txn_q, txn_d;
   logic        tx_ready_q, tx_ready_d;
   logic        tx_busy_q, tx_busy_d;
   logic        tx_underrun_q, tx_underrun_d;

   logic        tick;
   logic        take;
   logic        enc_bit;

   always_comb begin
      tick          = (div_cnt_q == DIV_LAST);
      div_cnt_d     = tick ? 8'd0 : div_cnt_q + 8'd1;
      take          = tx_ready_q & tx_valid;
      state_d       = state_q;
      half_d        = half_q;
      byte_cnt_d    = byte_cnt_q;
      shift_d       = shift_q;
      last_d        = last_q;
      // The byte may be accepted on the tick edge itself (CLK_DIV=1), so the
      // tick logic below sees the handshake through the *_d view of the hold.
      hold_byte_d   = take ? tx_data : hold_byte_q;
      hold_last_d   = take ? tx_last : hold_last_q;
      hold_vld_d    = hold_vld_q | take;
      nlp_cnt_d     = nlp_cnt_q;
      nlp_ph_d      = nlp_ph_q;
      tx_ready_d    = 1'b0;
      tx_underrun_d = tx_ready_q & ~tx_valid;

      if (tick) begin
         case (state_q)
            S_IDLE: begin
               if (tx_valid) begin
                  state_d    = S_PRE;
                  half_d     = 8'd0;
                  byte_cnt_d = 4'd0;
                  shift_d    = 8'h55;
                  last_d     = 1'b0;
               end else if (nlp_ph_q && (nlp_cnt_q == NLP_MAX)) begin
                  state_d = S_NLP;
                  half_d  = 8'd0;
               end else begin
                  nlp_ph_d = ~nlp_ph_q;
                  if (nlp_ph_q && (nlp_cnt_q != NLP_MAX)) nlp_cnt_d = nlp_cnt_q + 20'd1;
               end
            end
            S_NLP, S_TPIDL: begin
               if (half_q == ((state_q == S_NLP) ? NLP_LAST : TPIDL_LAST)) begin
                  state_d   = S_IDLE;
                  nlp_cnt_d = 20'd0;
                  nlp_ph_d  = 1'b0;
               end else begin
                  half_d = half_q + 8'd1;
               end
            end
            default: begin
               if (half_q != 8'd15) begin
                  half_d = half_q + 8'd1;
                  if ((half_q == 8'd14) && ((state_q == S_SFD) || ((state_q == S_DATA) && !last_q)))
                     tx_ready_d = 1'b1;
               end else begin
                  half_d = 8'd0;
                  if (state_q == S_PRE) begin
                     if (byte_cnt_q == PRE_LAST) begin
                        state_d = S_SFD;
                        shift_d = 8'hD5;
                     end else begin
                        byte_cnt_d = byte_cnt_q + 4'd1;
                     end
                  end else if (hold_vld_d) begin
                     state_d    = S_DATA;
                     shift_d    = hold_byte_d;
                     last_d     = hold_last_d;
                     hold_vld_d = 1'b0;
                  end else begin
                     state_d = S_TPIDL;
                  end
               end
            end
         endcase
      end

      enc_bit = shift_d[half_d[3:1]];
      case (state_d)
         S_IDLE:         begin txp_d = 1'b0; txn_d = 1'b0; end
         S_NLP, S_TPIDL: begin txp_d = 1'b1; txn_d = 1'b0; end
         default: begin
            txp_d = half_d[0] ? enc_bit : ~enc_bit;
            txn_d = ~txp_d;
         end
      endcase
      tx_busy_d = (state_d != S_IDLE) && (state_d != S_NLP);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= S_IDLE;
         div_cnt_q     <= 8'd0;
         half_q        <= 8'd0;
         byte_cnt_q    <= 4'd0;
         shift_q       <= 8'd0;
         last_q        <= 1'b0;
         hold_byte_q   <= 8'd0;
         hold_last_q   <= 1'b0;
         hold_vld_q    <= 1'b0;
         nlp_cnt_q     <= 20'd0;
         nlp_ph_q      <= 1'b0;
         txp_q         <= 1'b0;
         txn_q         <= 1'b0;
         tx_ready_q    <= 1'b0;
         tx_busy_q     <= 1'b0;
         tx_underrun_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         div_cnt_q     <= div_cnt_d;
         half_q        <= half_d;
         byte_cnt_q    <= byte_cnt_d;
         shift_q       <= shift_d;
         last_q        <= last_d;
         hold_byte_q   <= hold_byte_d;
         hold_last_q   <= hold_last_d;
         hold_vld_q    <= hold_vld_d;
         nlp_cnt_q     <= nlp_cnt_d;
         nlp_ph_q      <= nlp_ph_d;
         txp_q         <= txp_d;
         txn_q         <= txn_d;
         tx_ready_q    <= tx_ready_d;
         tx_busy_q     <= tx_busy_d;
         tx_underrun_q <= tx_underrun_d;
      end
   end

   assign Txp         = txp_q;
   assign Txn         = txn_q;
   assign tx_ready    = tx_ready_q;
   assign tx_busy     = tx_busy_q;
   assign tx_underrun = tx_underrun_q;

endmodule
